spi_controller: RTL and testbench

SPI write-only controller that drives the 16-bit register-write frame consumed by the chip's SPI register peripheral. One write command at a time is accepted on a valid/ready interface and serialised MSB-first on `sclk`/`copi` under `ncs`. Used as the on-chip or bench-side initiator for the PWM configuration registers at addresses 0x00–0x04. SPI mode 0: `sclk` idles low, `copi` changes on the falling edge, and the peripheral samples on the rising edge.

---
 rtl/spi_ctrl_pkg.sv | 30 +++
 rtl/spi_ctrl_phase_timer.sv | 28 ++
 rtl/spi_controller.sv | 167 ++++++++++++++++
 tb/tb_spi_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-write controller.
// Frame layout: {write flag, 7-bit address, 8-bit data}, MSB first.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_GAP
    } state_t;

    localparam int         FRAME_BITS   = 16;
    localparam logic       WRITE_FLAG   = 1'b1;
    localparam logic [6:0] REG_ADDR_MAX = 7'h04;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {WRITE_FLAG, addr, data};
    endfunction

endpackage

// File: rtl/spi_ctrl_phase_timer.sv
// Loadable down-counter; expire ticks in the last cycle of a phase.
// Load with (phase length - 1) on the cycle the phase is entered.
module spi_ctrl_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller for the 16-bit register-write frame.
// Define SPI_CONTROLLER_ADDR_CHECK_EN to reject addresses above REG_ADDR_MAX.
module spi_controller
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
    output logic       err,
`endif
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    localparam int PH_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int PW     = $clog2(PH_MAX + 1);

    localparam logic [PW-1:0] DIV_LD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LD = PW'(CS_IDLE - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_controller: CLK_DIV must be >= 2");
    end
    if (CS_IDLE < 4) begin : g_bad_idle
        $error("spi_controller: CS_IDLE must be >= 4");
    end

    state_t          state_q, state_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic            tm_load;
    logic [PW-1:0]   tm_val;
    logic            tm_expire;
    logic            accept;
    logic            addr_bad;
    logic            frame_on_d;
    logic            done_d, err_d;
    logic            ncs_q, sclk_q, copi_q, done_q, err_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
    assign addr_bad = (cmd_addr > REG_ADDR_MAX);
    assign err      = err_q;
`else
    assign addr_bad = 1'b0;
`endif

    spi_ctrl_phase_timer #(
        .W (PW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state_q != ST_IDLE),
        .load     (tm_load),
        .load_val (tm_val),
        .expire   (tm_expire)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tm_load   = 1'b0;
        tm_val    = DIV_LD;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_SETUP;
                        shreg_d   = make_frame(cmd_addr, cmd_data);
                        bit_cnt_d = '0;
                        tm_load   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (tm_expire) begin
                    state_d = ST_SHIFT_HI;
                    tm_load = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                // Shift on the falling sclk edge so copi moves with it.
                if (tm_expire) begin
                    state_d = ST_SHIFT_LO;
                    shreg_d = {shreg_q[14:0], 1'b0};
                    tm_load = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (tm_expire) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    tm_load   = 1'b1;
                    if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                        state_d = ST_GAP;
                        tm_val  = GAP_LD;
                    end else begin
                        state_d = ST_SHIFT_HI;
                    end
                end
            end
            ST_GAP: begin
                if (tm_expire) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame_on_d = (state_d == ST_SETUP) ||
                        (state_d == ST_SHIFT_HI) ||
                        (state_d == ST_SHIFT_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // SPI pins and pulses are flops fed from next-state, so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_q  <= 1'b1;
            sclk_q <= 1'b0;
            copi_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ncs_q  <= !frame_on_d;
            sclk_q <= (state_d == ST_SHIFT_HI);
            copi_q <= frame_on_d && shreg_d[15];
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign ncs  = ncs_q;
    assign sclk = sclk_q;
    assign copi = copi_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: two controllers (CLK_DIV=4 and CLK_DIV=2) with a
// bench-side model of the SPI register peripheral on each.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] cmd_valid;
    logic [6:0] cmd_addr [2];
    logic [7:0] cmd_data [2];
    logic [1:0] cmd_ready, busy, done, sclk, ncs, copi;
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
    logic [1:0] err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_controller #(.CLK_DIV(4), .CS_IDLE(4)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n[0]),
        .cmd_valid (cmd_valid[0]),
        .cmd_addr  (cmd_addr[0]),
        .cmd_data  (cmd_data[0]),
        .cmd_ready (cmd_ready[0]),
        .busy      (busy[0]),
        .done      (done[0]),
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
        .err       (err[0]),
`endif
        .sclk      (sclk[0]),
        .ncs       (ncs[0]),
        .copi      (copi[0])
    );

    spi_controller #(.CLK_DIV(2), .CS_IDLE(4)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n[1]),
        .cmd_valid (cmd_valid[1]),
        .cmd_addr  (cmd_addr[1]),
        .cmd_data  (cmd_data[1]),
        .cmd_ready (cmd_ready[1]),
        .busy      (busy[1]),
        .done      (done[1]),
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
        .err       (err[1]),
`endif
        .sclk      (sclk[1]),
        .ncs       (ncs[1]),
        .copi      (copi[1])
    );

    // Peripheral model: shift copi on sclk rise, commit on ncs rise.
    for (genvar g = 0; g < 2; g++) begin : mon
        int          nbits      = 0;
        int          last_nbits = 0;
        int          cur_low    = 0;
        int          low_len    = 0;
        int          done_n     = 0;
        int          acc_n      = 0;
        int          acc_t      = 0;
        int          acc_dt     = 0;
        logic [15:0] sr         = '0;
        logic [15:0] last_frame = '0;
        logic [7:0]  regs [5]   = '{default: 8'h00};
        logic        sclk_p     = 1'b0;
        logic        ncs_p      = 1'b1;

        always @(posedge clk) begin
            sclk_p <= sclk[g];
            ncs_p  <= ncs[g];
            if (ncs_p === 1'b1 && ncs[g] === 1'b0)
                nbits <= 0;
            else if (ncs[g] === 1'b0 && sclk[g] === 1'b1 && sclk_p === 1'b0) begin
                sr    <= {sr[14:0], copi[g]};
                nbits <= nbits + 1;
            end
            if (ncs[g] === 1'b0)
                cur_low <= cur_low + 1;
            else if (ncs_p === 1'b0) begin
                low_len    <= cur_low;
                cur_low    <= 0;
                last_nbits <= nbits;
                last_frame <= sr;
                if (nbits == 16 && sr[15] && sr[14:8] <= 7'h04)
                    regs[sr[10:8]] <= sr[7:0];
            end
            if (cmd_valid[g] && cmd_ready[g]) begin
                acc_n  <= acc_n + 1;
                acc_t  <= cyc;
                acc_dt <= cyc - acc_t;
            end
            if (done[g] === 1'b1)
                done_n <= done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int g, input int budget, input string tag);
        int n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done[g]), 32'd1);
    endtask

    task automatic send(input int g, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        cmd_valid[g] = 1'b1;
        cmd_addr[g]  = a;
        cmd_data[g]  = d;
        while (cmd_ready[g] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid[g] = 1'b0;
    endtask

    int          n;
    logic        rdy_seen;
    int          frames_before;

    initial begin
        rst_n     = 2'b00;
        cmd_valid = 2'b00;
        cmd_addr  = '{7'h00, 7'h00};
        cmd_data  = '{8'h00, 8'h00};
        repeat (3) @(negedge clk);

        check("rst_ncs",   32'(ncs[0]),       32'd1);
        check("rst_sclk",  32'(sclk[0]),      32'd0);
        check("rst_copi",  32'(copi[0]),      32'd0);
        check("rst_done",  32'(done[0]),      32'd0);
        check("rst_busy",  32'(busy[0]),      32'd0);
        check("rst_ready", 32'(cmd_ready[0]), 32'd1);
        rst_n = 2'b11;
        @(negedge clk);

        // Single write 0x04 <= 0x80
        send(0, 7'h04, 8'h80);
        check("acc_ncs_low", 32'(ncs[0]),       32'd0);
        check("acc_busy",    32'(busy[0]),      32'd1);
        check("acc_ready",   32'(cmd_ready[0]), 32'd0);
        check("acc_copi",    32'(copi[0]),      32'd1);
        wait_done(0, 200, "single_done");
        @(negedge clk);
        check("single_done_pulse", 32'(done[0]), 32'd0);
        check("single_done_n",   32'(mon[0].done_n),     32'd1);
        check("single_frame",    32'(mon[0].last_frame), 32'h8480);
        check("single_nbits",    32'(mon[0].last_nbits), 32'd16);
        check("single_ncs_low",  32'(mon[0].low_len),    32'd132);
        check("single_reg4",     32'(mon[0].regs[4]),    32'h80);

        // Back-to-back with cmd_valid held high
        cmd_valid[0] = 1'b1;
        cmd_addr[0]  = 7'h00;
        cmd_data[0]  = 8'hA5;
        @(negedge clk);
        cmd_addr[0]  = 7'h02;
        cmd_data[0]  = 8'h3C;
        n = 0;
        while (cmd_ready[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_with_ready", 32'(done[0]), 32'd1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("b2b_period", 32'(mon[0].acc_dt), 32'd137);
        wait_done(0, 200, "b2b_done");
        @(negedge clk);
        check("b2b_reg0", 32'(mon[0].regs[0]), 32'hA5);
        check("b2b_reg2", 32'(mon[0].regs[2]), 32'h3C);

        // Held command, data changed mid-frame
        cmd_valid[0] = 1'b1;
        cmd_addr[0]  = 7'h03;
        cmd_data[0]  = 8'h11;
        @(negedge clk);
        cmd_data[0]  = 8'h99;
        rdy_seen = 1'b0;
        n = 0;
        while (ncs[0] !== 1'b1 && n < 200) begin
            rdy_seen |= cmd_ready[0];
            @(negedge clk);
            n++;
        end
        rdy_seen |= cmd_ready[0];
        cmd_valid[0] = 1'b0;
        check("held_ready_low", 32'(rdy_seen), 32'd0);
        wait_done(0, 50, "held_done");
        @(negedge clk);
        check("held_frame", 32'(mon[0].last_frame), 32'h8311);
        check("held_reg3",  32'(mon[0].regs[3]),    32'h11);

        // Reset after the 9th rising sclk edge
        send(0, 7'h01, 8'h5A);
        n = 0;
        while (mon[0].nbits != 9 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reach9", 32'(mon[0].nbits), 32'd9);
        rst_n[0] = 1'b0;
        #1;
        check("rstmid_ncs",  32'(ncs[0]),  32'd1);
        check("rstmid_sclk", 32'(sclk[0]), 32'd0);
        check("rstmid_copi", 32'(copi[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        check("rstmid_nbits", 32'(mon[0].last_nbits), 32'd9);
        check("rstmid_reg1",  32'(mon[0].regs[1]),    32'h00);
        send(0, 7'h01, 8'h5A);
        wait_done(0, 200, "rstmid_next_done");
        @(negedge clk);
        check("rstmid_next_reg1", 32'(mon[0].regs[1]), 32'h5A);

        // Out-of-map address 0x05
        frames_before = mon[0].done_n;
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
        send(0, 7'h05, 8'h77);
        check("oom_err",   32'(err[0]),       32'd1);
        check("oom_ncs",   32'(ncs[0]),       32'd1);
        check("oom_ready", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk);
        check("oom_err_pulse", 32'(err[0]),  32'd0);
        repeat (4) @(negedge clk);
        check("oom_ncs_after", 32'(ncs[0]), 32'd1);
        check("oom_no_done", 32'(mon[0].done_n), 32'(frames_before));
`else
        send(0, 7'h05, 8'h77);
        wait_done(0, 200, "oom_done");
        @(negedge clk);
        check("oom_frame", 32'(mon[0].last_frame), 32'h8577);
        check("oom_nbits", 32'(mon[0].last_nbits), 32'd16);
`endif
        check("oom_reg0", 32'(mon[0].regs[0]), 32'hA5);
        check("oom_reg1", 32'(mon[0].regs[1]), 32'h5A);
        check("oom_reg2", 32'(mon[0].regs[2]), 32'h3C);
        check("oom_reg3", 32'(mon[0].regs[3]), 32'h11);
        check("oom_reg4", 32'(mon[0].regs[4]), 32'h80);

        // Minimum divider
        send(1, 7'h01, 8'hFF);
        check("div2_ncs_low_start", 32'(ncs[1]), 32'd0);
        wait_done(1, 150, "div2_done");
        @(negedge clk);
        check("div2_frame",   32'(mon[1].last_frame), 32'h81FF);
        check("div2_nbits",   32'(mon[1].last_nbits), 32'd16);
        check("div2_ncs_low", 32'(mon[1].low_len),    32'd66);
        check("div2_reg1",    32'(mon[1].regs[1]),    32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
